// File: rtl/noc_packet_collector_mf_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_packet_collector_mf_if                                                 |
// | Local-port flit handshake and packet result bundle for the collector.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface noc_packet_collector_mf_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PID_W      = 10,
  parameter int SID_W      = 6,
  parameter int TS_W       = 14,
  parameter int LEN_W      = 5
);
  logic [DATA_WIDTH-1:0] PacketIn;
  logic                  ReqUpStr;
  logic                  GntUpStr;
  logic                  UpStrFull;
  logic                  DrainEn;
  logic                  PktValid;
  logic [PID_W-1:0]      PktID;
  logic [SID_W-1:0]      PktSender;
  logic [TS_W-1:0]       PktLatency;
  logic [LEN_W-1:0]      PktLen;
  logic [31:0]           PktCount;
  logic                  ErrFlag;

  modport master (
    output PacketIn, ReqUpStr, DrainEn,
    input  GntUpStr, UpStrFull, PktValid, PktID, PktSender, PktLatency,
           PktLen, PktCount, ErrFlag
  );

  modport slave (
    input  PacketIn, ReqUpStr, DrainEn,
    output GntUpStr, UpStrFull, PktValid, PktID, PktSender, PktLatency,
           PktLen, PktCount, ErrFlag
  );
endinterface
`default_nettype wire

// File: rtl/noc_packet_collector_mf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_packet_collector_mf                                                    |
// | Multi-flit NoC packet sink: flit FIFO, reassembly, latency and error stats.|
// | Optional macro COLLECTOR_LOG_EN adds a simulation-only packet log.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module noc_packet_collector_mf #(
  parameter int         DATA_WIDTH = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter int         PID_W      = 10,
  parameter int         SID_W      = 6,
  parameter int         TS_W       = 14,
  parameter int         MAX_FLITS  = 16,
  parameter logic [5:0] MODULE_ID  = 6'd0
) (
  input  logic                      clk,
  input  logic                      reset,
  noc_packet_collector_mf_if.slave  bus
);

  localparam int LEN_W = $clog2(MAX_FLITS) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  if ((2 + PID_W + SID_W + TS_W > DATA_WIDTH) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (MAX_FLITS < 2) ||
      (int'(MODULE_ID) >= (1 << SID_W))) begin : g_bad_params
    $error("noc_packet_collector_mf: illegal parameter combination");
  end

  // Flit FIFO
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic                  gnt_q, gnt_d, full_q, full_d;
  logic                  push, pop;

  assign push = bus.ReqUpStr & gnt_q;
  assign pop  = bus.DrainEn & (occ_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    occ_d    = occ_q + CNT_W'(push) - CNT_W'(pop);
    gnt_d    = (occ_d < CNT_W'(FIFO_DEPTH));
    full_d   = (occ_d == CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.PacketIn;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      gnt_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      gnt_q    <= gnt_d;
      full_q   <= full_d;
    end
  end

  // Head-of-FIFO flit decode; only meaningful on a pop
  logic [DATA_WIDTH-1:0] flit;
  logic [1:0]            f_type;
  logic [PID_W-1:0]      f_id;
  logic [SID_W-1:0]      f_sid;
  logic [TS_W-1:0]       f_ts;

  assign flit   = mem_q[rd_ptr_q];
  assign f_type = flit[DATA_WIDTH-1 -: 2];
  assign f_id   = flit[DATA_WIDTH-3 -: PID_W];
  assign f_sid  = flit[DATA_WIDTH-3-PID_W -: SID_W];
  assign f_ts   = flit[TS_W-1:0];

  logic [0:0]       state_q, state_d;
  logic [TS_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [PID_W-1:0] cur_id_q, cur_id_d;
  logic [SID_W-1:0] cur_sid_q, cur_sid_d;
  logic [TS_W-1:0]  cur_ts_q, cur_ts_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic [PID_W-1:0] pkt_id_q, pkt_id_d;
  logic [SID_W-1:0] pkt_sender_q, pkt_sender_d;
  logic [TS_W-1:0]  pkt_latency_q, pkt_latency_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic [31:0]      pkt_count_q, pkt_count_d;
  logic             err_q, err_d;
  logic             err_set, done;
  logic [PID_W-1:0] done_id;
  logic [SID_W-1:0] done_sid;
  logic [TS_W-1:0]  done_ts;
  logic [LEN_W-1:0] done_len;
  logic             len_at_max;

  assign len_at_max  = (len_q >= LEN_W'(MAX_FLITS - 1));
  assign cycle_cnt_d = cycle_cnt_q + TS_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (pop) begin
      case (f_type)
        FT_HEAD:   state_d = ST_BODY;
        FT_SINGLE: state_d = ST_IDLE;
        FT_BODY:   if (state_q == ST_BODY && len_at_max) state_d = ST_IDLE;
        FT_TAIL:   state_d = ST_IDLE;
        default:   state_d = state_q;
      endcase
    end
  end

  // A head or single arriving mid-packet flags the error, then restarts cleanly
  always_comb begin
    err_set   = 1'b0;
    done      = 1'b0;
    cur_id_d  = cur_id_q;
    cur_sid_d = cur_sid_q;
    cur_ts_d  = cur_ts_q;
    len_d     = len_q;
    done_id   = f_id;
    done_sid  = f_sid;
    done_ts   = f_ts;
    done_len  = LEN_W'(1);
    if (pop) begin
      case (f_type)
        FT_HEAD: begin
          err_set   = (state_q == ST_BODY);
          cur_id_d  = f_id;
          cur_sid_d = f_sid;
          cur_ts_d  = f_ts;
          len_d     = LEN_W'(1);
        end
        FT_SINGLE: begin
          err_set = (state_q == ST_BODY);
          done    = 1'b1;
        end
        FT_BODY: begin
          if (state_q == ST_IDLE || len_at_max) err_set = 1'b1;
          else                                  len_d   = len_q + LEN_W'(1);
        end
        FT_TAIL: begin
          if (state_q == ST_IDLE) begin
            err_set = 1'b1;
          end else begin
            done     = 1'b1;
            done_id  = cur_id_q;
            done_sid = cur_sid_q;
            done_ts  = cur_ts_q;
            done_len = len_q + LEN_W'(1);
          end
        end
        default: err_set = 1'b0;
      endcase
    end
    pkt_valid_d   = done;
    pkt_id_d      = done ? done_id : pkt_id_q;
    pkt_sender_d  = done ? done_sid : pkt_sender_q;
    pkt_len_d     = done ? done_len : pkt_len_q;
    pkt_latency_d = done ? (cycle_cnt_q - done_ts) : pkt_latency_q;
    pkt_count_d   = (done && pkt_count_q != '1) ? pkt_count_q + 32'd1 : pkt_count_q;
    err_d         = err_q | err_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      cur_id_q      <= '0;
      cur_sid_q     <= '0;
      cur_ts_q      <= '0;
      len_q         <= '0;
      pkt_valid_q   <= 1'b0;
      pkt_id_q      <= '0;
      pkt_sender_q  <= '0;
      pkt_latency_q <= '0;
      pkt_len_q     <= '0;
      pkt_count_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      cur_id_q      <= cur_id_d;
      cur_sid_q     <= cur_sid_d;
      cur_ts_q      <= cur_ts_d;
      len_q         <= len_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_id_q      <= pkt_id_d;
      pkt_sender_q  <= pkt_sender_d;
      pkt_latency_q <= pkt_latency_d;
      pkt_len_q     <= pkt_len_d;
      pkt_count_q   <= pkt_count_d;
      err_q         <= err_d;
    end
  end

  assign bus.GntUpStr   = gnt_q;
  assign bus.UpStrFull  = full_q;
  assign bus.PktValid   = pkt_valid_q;
  assign bus.PktID      = pkt_id_q;
  assign bus.PktSender  = pkt_sender_q;
  assign bus.PktLatency = pkt_latency_q;
  assign bus.PktLen     = pkt_len_q;
  assign bus.PktCount   = pkt_count_q;
  assign bus.ErrFlag    = err_q;

`ifdef COLLECTOR_LOG_EN
  always @(posedge clk) begin
    if (pkt_valid_q)
      $display("Collector_Log_%0d: %0t ; %0d ; %0d ; %0d ; %0d ; %0d ; %0d", MODULE_ID, $time,
               cycle_cnt_q, pkt_sender_q, MODULE_ID, pkt_id_q, pkt_latency_q, pkt_len_q);
    if (reset && err_set)
      $display("Collector_Log_%0d: ERR %0t", MODULE_ID, $time);
  end
`else
  // Synthesizable build: no logging side channel.
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_packet_collector_mf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_noc_packet_collector_mf                                                 |
// | Directed + random stimulus against a packet-level reference model.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_noc_packet_collector_mf;
  localparam int DW = 32, DEPTH = 4, PID_W = 10, SID_W = 6, TS_W = 14, MAXF = 16, LEN_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  noc_packet_collector_mf_if #(.DATA_WIDTH(DW), .PID_W(PID_W), .SID_W(SID_W),
                               .TS_W(TS_W), .LEN_W(LEN_W)) bus ();

  noc_packet_collector_mf #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PID_W(PID_W),
                            .SID_W(SID_W), .TS_W(TS_W), .MAX_FLITS(MAXF),
                            .MODULE_ID(6'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0, n_fail = 0;

  // Reference model: FIFO as a queue, packet under assembly as a list of flits
  logic [DW-1:0]    mq[$];
  logic [DW-1:0]    mpkt[$];
  int unsigned      m_cyc;
  bit               m_gnt, m_full;
  logic             e_valid, e_err;
  logic [PID_W-1:0] e_id;
  logic [SID_W-1:0] e_sid;
  logic [TS_W-1:0]  e_lat;
  logic [LEN_W-1:0] e_len;
  logic [31:0]      e_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int id, input int sid, input int ts);
    return {t, PID_W'(id), SID_W'(sid), TS_W'(ts)};
  endfunction

  function automatic logic [DW-1:0] rnd_flit(input logic [1:0] t);
    logic [DW-1:0] r;
    r = DW'($urandom);
    r[DW-1:DW-2] = t;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    mpkt.delete();
    m_cyc = 0;
    m_gnt = 0; m_full = 0;
    e_valid = 0; e_err = 0; e_id = '0; e_sid = '0; e_lat = '0; e_len = '0; e_cnt = '0;
  endtask

  task automatic model_complete();
    logic [DW-1:0] h;
    h = mpkt[0];
    e_valid = 1;
    e_id    = h[DW-3 -: PID_W];
    e_sid   = h[DW-3-PID_W -: SID_W];
    e_lat   = TS_W'(m_cyc - 32'(h[TS_W-1:0]));
    e_len   = LEN_W'(mpkt.size());
    if (e_cnt != 32'hFFFF_FFFF) e_cnt++;
    mpkt.delete();
  endtask

  task automatic model_flit(input logic [DW-1:0] f);
    case (f[DW-1:DW-2])
      2'b01, 2'b11: begin
        if (mpkt.size() != 0) begin e_err = 1; mpkt.delete(); end
        mpkt.push_back(f);
        if (f[DW-1:DW-2] == 2'b11) model_complete();
      end
      2'b00: begin
        if (mpkt.size() == 0) e_err = 1;
        else if (mpkt.size() + 1 > MAXF - 1) begin e_err = 1; mpkt.delete(); end
        else mpkt.push_back(f);
      end
      default: begin
        if (mpkt.size() == 0) e_err = 1;
        else begin mpkt.push_back(f); model_complete(); end
      end
    endcase
  endtask

  task automatic model_edge(input bit req, input logic [DW-1:0] f, input bit drain);
    bit push, pop;
    push = req && m_gnt;
    pop  = drain && (mq.size() > 0);
    e_valid = 0;
    if (pop) model_flit(mq.pop_front());
    if (push) mq.push_back(f);
    m_cyc = (m_cyc + 1) % (1 << TS_W);
    m_gnt  = (mq.size() < DEPTH);
    m_full = (mq.size() == DEPTH);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},  64'(bus.GntUpStr),   64'(m_gnt));
    chk({tag, ".full"}, 64'(bus.UpStrFull),  64'(m_full));
    chk({tag, ".vld"},  64'(bus.PktValid),   64'(e_valid));
    chk({tag, ".id"},   64'(bus.PktID),      64'(e_id));
    chk({tag, ".sid"},  64'(bus.PktSender),  64'(e_sid));
    chk({tag, ".lat"},  64'(bus.PktLatency), 64'(e_lat));
    chk({tag, ".len"},  64'(bus.PktLen),     64'(e_len));
    chk({tag, ".cnt"},  64'(bus.PktCount),   64'(e_cnt));
    chk({tag, ".err"},  64'(bus.ErrFlag),    64'(e_err));
  endtask

  int n_vld;

  task automatic step(input bit req, input logic [DW-1:0] f, input bit drain, input string tag);
    bus.ReqUpStr = req;
    bus.PacketIn = f;
    bus.DrainEn  = drain;
    @(posedge clk);
    model_edge(req, f, drain);
    #1;
    check_all(tag);
    n_vld += int'(bus.PktValid);
  endtask

  task automatic do_reset();
    bus.ReqUpStr = 0; bus.DrainEn = 0; bus.PacketIn = '0;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    reset = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] pk[4];
    logic [31:0]   cnt0;
    bus.ReqUpStr = 0; bus.DrainEn = 0; bus.PacketIn = '0;
    #3;
    do_reset();

    // 1: single flit pushed at CycleCnt=3
    step(0, '0, 1, "t1.idle0");
    chk("t1.gnt_first", 64'(bus.GntUpStr), 64'd1);
    step(0, '0, 1, "t1.idle1");
    step(0, '0, 1, "t1.idle2");
    step(1, mk(2'b11, 5, 6'o12, 0), 1, "t1.push");
    step(0, '0, 1, "t1.pop");
    chk("t1.vld", 64'(bus.PktValid), 64'd1);
    chk("t1.id",  64'(bus.PktID), 64'd5);
    chk("t1.sid", 64'(bus.PktSender), 64'(6'o12));
    chk("t1.len", 64'(bus.PktLen), 64'd1);
    chk("t1.lat", 64'(bus.PktLatency), 64'd4);
    chk("t1.cnt", 64'(bus.PktCount), 64'd1);
    step(0, '0, 1, "t1.after");
    chk("t1.vld_pulse", 64'(bus.PktValid), 64'd0);

    // 2: four-flit packet back-to-back
    pk[0] = mk(2'b01, 7, 3, int'(m_cyc));
    pk[1] = rnd_flit(2'b00);
    pk[2] = rnd_flit(2'b00);
    pk[3] = rnd_flit(2'b10);
    n_vld = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, pk[i], 1, "t2.flit");
      chk("t2.gnt", 64'(bus.GntUpStr), 64'd1);
    end
    step(0, '0, 1, "t2.drain0");
    step(0, '0, 1, "t2.drain1");
    chk("t2.len", 64'(bus.PktLen), 64'd4);
    chk("t2.err", 64'(bus.ErrFlag), 64'd0);
    chk("t2.pulses", 64'(n_vld), 64'd1);

    // Longest legal packet: MAX_FLITS flits
    step(1, mk(2'b01, 9, 4, int'(m_cyc)), 1, "tmax.head");
    for (int i = 0; i < MAXF - 2; i++) step(1, rnd_flit(2'b00), 1, "tmax.body");
    step(1, rnd_flit(2'b10), 1, "tmax.tail");
    step(0, '0, 1, "tmax.drain0");
    step(0, '0, 1, "tmax.drain1");
    chk("tmax.len", 64'(bus.PktLen), 64'd16);
    chk("tmax.err", 64'(bus.ErrFlag), 64'd0);

    // 3: backpressure
    pk[0] = mk(2'b01, 11, 2, int'(m_cyc));
    pk[1] = rnd_flit(2'b00);
    pk[2] = rnd_flit(2'b00);
    pk[3] = rnd_flit(2'b10);
    for (int i = 0; i < 4; i++) step(1, pk[i], 0, "t3.fill");
    chk("t3.full", 64'(bus.UpStrFull), 64'd1);
    chk("t3.gnt0", 64'(bus.GntUpStr), 64'd0);
    step(1, rnd_flit(2'b00), 0, "t3.refused0");
    step(1, rnd_flit(2'b00), 0, "t3.refused1");
    chk("t3.gnt_held", 64'(bus.GntUpStr), 64'd0);
    step(0, '0, 1, "t3.pop1");
    chk("t3.gnt_back", 64'(bus.GntUpStr), 64'd1);
    chk("t3.full_off", 64'(bus.UpStrFull), 64'd0);
    repeat (4) step(0, '0, 1, "t3.drain");
    chk("t3.len", 64'(bus.PktLen), 64'd4);
    chk("t3.id",  64'(bus.PktID), 64'd11);
    chk("t3.err", 64'(bus.ErrFlag), 64'd0);

    // 4: stray body, then head abandoned by a second head
    cnt0 = bus.PktCount;
    n_vld = 0;
    step(1, rnd_flit(2'b00), 1, "t4.body");
    step(1, mk(2'b01, 20, 1, int'(m_cyc)), 1, "t4.headA");
    step(1, mk(2'b01, 21, 2, int'(m_cyc)), 1, "t4.headB");
    step(1, rnd_flit(2'b10), 1, "t4.tail");
    step(0, '0, 1, "t4.drain0");
    step(0, '0, 1, "t4.drain1");
    chk("t4.err", 64'(bus.ErrFlag), 64'd1);
    chk("t4.id",  64'(bus.PktID), 64'd21);
    chk("t4.len", 64'(bus.PktLen), 64'd2);
    chk("t4.cnt", 64'(bus.PktCount), 64'(cnt0 + 32'd1));
    chk("t4.pulses", 64'(n_vld), 64'd1);

    // Oversized packet is dropped without a completion
    cnt0 = bus.PktCount;
    n_vld = 0;
    step(1, mk(2'b01, 30, 5, int'(m_cyc)), 1, "tovf.head");
    for (int i = 0; i < MAXF - 1; i++) step(1, rnd_flit(2'b00), 1, "tovf.body");
    step(1, rnd_flit(2'b10), 1, "tovf.tail");
    step(0, '0, 1, "tovf.drain0");
    step(0, '0, 1, "tovf.drain1");
    chk("tovf.cnt", 64'(bus.PktCount), 64'(cnt0));
    chk("tovf.pulses", 64'(n_vld), 64'd0);

    // 5: latency wrap, tail popped at CycleCnt=3
    do_reset();
    step(0, '0, 1, "t5.idle");
    step(1, mk(2'b01, 40, 5, 14'h3FFE), 1, "t5.head");
    step(1, rnd_flit(2'b10), 1, "t5.tail");
    step(0, '0, 1, "t5.pop");
    chk("t5.vld", 64'(bus.PktValid), 64'd1);
    chk("t5.lat", 64'(bus.PktLatency), 64'd5);
    chk("t5.cnt", 64'(bus.PktCount), 64'd1);

    // 6: reset with three flits buffered
    step(1, mk(2'b01, 50, 6, int'(m_cyc)), 0, "t6.head");
    step(1, rnd_flit(2'b00), 0, "t6.body0");
    step(1, rnd_flit(2'b00), 0, "t6.body1");
    do_reset();
    chk("t6.cnt_rst", 64'(bus.PktCount), 64'd0);
    step(0, '0, 1, "t6.idle");
    step(1, mk(2'b11, 51, 7, int'(m_cyc)), 1, "t6.push");
    step(0, '0, 1, "t6.pop");
    chk("t6.vld", 64'(bus.PktValid), 64'd1);
    chk("t6.cnt", 64'(bus.PktCount), 64'd1);
    chk("t6.len", 64'(bus.PktLen), 64'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit r, d;
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) != 0);
      step(r, DW'($urandom), d, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
